// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of a single-ported RAM.
//
// Master 0 is the CPU data port and master 1 is the loader/DMA port. Each
// master raises mX_req and holds its qualifiers until it sees mX_ack. An
// access takes exactly one GNT cycle. Requests at or above RAM_BYTES are
// acknowledged with mX_err and do not reach the RAM. Master 1 can take
// exclusive ownership with m1_lock. While it holds the lock, master 0 is
// never granted.
//
// Ports
//   clk, rst                          clock, asynchronous active-high reset
//   m0_req/we/addr/sel/wdata          master 0 request and qualifiers
//   m0_ack/err/rdata                  master 0 completion, error, read data
//   m1_req/we/addr/sel/wdata/lock     master 1 request, qualifiers and lock
//   m1_ack/err/rdata                  master 1 completion, error, read data
//   ram_en/we/addr/sel/wdata          RAM control and write data
//   ram_rdata                         RAM combinational read data
//   locked                            master 1 currently holds exclusive ownership
module mem_arbiter #(
    parameter int RAM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        locked
);

    localparam logic [31:0] RAM_LIMIT = 32'(RAM_BYTES);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state, state_next;
    logic   locked_next;
    logic   m0_oor, m1_oor;

    assign m0_oor = (m0_addr >= RAM_LIMIT);
    assign m1_oor = (m1_addr >= RAM_LIMIT);

    // The lock follows m1_lock once master 1 has had a grant, and it stays
    // live until master 1 drops m1_lock. A stray m1_lock seen outside that
    // window does nothing.
    assign locked_next = ((state == GNT1) || locked) ? m1_lock : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            locked <= 1'b0;
        end else begin
            state  <= state_next;
            locked <= locked_next;
        end
    end

    // In GNTx the next state ignores master x's request. That request is
    // still high while it is being acked, so the other master gets the next
    // slot. If the other master is not requesting, the arbiter passes through
    // an IDLE bubble.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (locked)      state_next = m1_req ? GNT1 : IDLE;
                else if (m0_req) state_next = GNT0;
                else if (m1_req) state_next = GNT1;
            end
            GNT0:    state_next = m1_req ? GNT1 : IDLE;
            GNT1:    state_next = (m0_req && !locked_next) ? GNT0 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode only from the registered state. For this reason an
    // asynchronous reset removes the RAM strobes at once.
    always_comb begin
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m0_rdata  = '0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        m1_rdata  = '0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_sel   = '0;
        ram_wdata = '0;
        case (state)
            GNT0: begin
                m0_ack = 1'b1;
                if (m0_oor) begin
                    m0_err = 1'b1;
                end else begin
                    ram_en    = 1'b1;
                    ram_we    = m0_we;
                    ram_addr  = m0_addr;
                    ram_sel   = m0_sel;
                    ram_wdata = m0_wdata;
                    m0_rdata  = m0_we ? 32'h0 : ram_rdata;
                end
            end
            GNT1: begin
                m1_ack = 1'b1;
                if (m1_oor) begin
                    m1_err = 1'b1;
                end else begin
                    ram_en    = 1'b1;
                    ram_we    = m1_we;
                    ram_addr  = m1_addr;
                    ram_sel   = m1_sel;
                    ram_wdata = m1_wdata;
                    m1_rdata  = m1_we ? 32'h0 : ram_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, ram_rdata;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_we, locked;
    logic [31:0] ram_addr, ram_wdata;
    logic [3:0]  ram_sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.RAM_BYTES(4096)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .locked(locked)
    );

    typedef struct packed {
        logic        m0_ack;
        logic        m0_err;
        logic [31:0] m0_rdata;
        logic        m1_ack;
        logic        m1_err;
        logic [31:0] m1_rdata;
        logic        ram_en;
        logic        ram_we;
        logic [31:0] ram_addr;
        logic [3:0]  ram_sel;
        logic [31:0] ram_wdata;
        logic        locked;
    } out_t;

    typedef struct {
        logic        m0r, m0w;
        logic [31:0] m0a;
        logic        m1r, m1w;
        logic [31:0] m1a;
        logic        lk;
        logic [31:0] rd;
        out_t        exp;
    } row_t;

    localparam logic [31:0] WD0 = 32'hA5A5_0000;
    localparam logic [31:0] WD1 = 32'h5A5A_0000;

    row_t rows[$];
    out_t exp_q[$];

    // One table row covers one clock cycle. The inputs are held for the whole
    // cycle, and the expected outputs are the values the DUT must show during
    // that cycle. The master's write data is derived from its address.
    function automatic row_t mk(
        input logic m0r, input logic m0w, input logic [31:0] m0a,
        input logic m1r, input logic m1w, input logic [31:0] m1a,
        input logic lk, input logic [31:0] rd,
        input logic ack0, input logic ack1, input logic err,
        input logic en, input logic we, input logic [31:0] ea,
        input logic [31:0] rd0, input logic [31:0] rd1, input logic elk);
        row_t r;
        r.m0r = m0r; r.m0w = m0w; r.m0a = m0a;
        r.m1r = m1r; r.m1w = m1w; r.m1a = m1a;
        r.lk = lk; r.rd = rd;
        r.exp.m0_ack    = ack0;
        r.exp.m0_err    = ack0 & err;
        r.exp.m0_rdata  = rd0;
        r.exp.m1_ack    = ack1;
        r.exp.m1_err    = ack1 & err;
        r.exp.m1_rdata  = rd1;
        r.exp.ram_en    = en;
        r.exp.ram_we    = we;
        r.exp.ram_addr  = ea;
        r.exp.ram_sel   = en ? (ack0 ? 4'hF : 4'h3) : 4'h0;
        r.exp.ram_wdata = en ? (ea ^ (ack0 ? WD0 : WD1)) : 32'h0;
        r.exp.locked    = elk;
        return r;
    endfunction

    function automatic row_t idle_row();
        return mk(0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0,0,0,0);
    endfunction

    function automatic out_t sample();
        out_t o;
        o = {m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
             ram_en, ram_we, ram_addr, ram_sel, ram_wdata, locked};
        return o;
    endfunction

    task automatic drive(input row_t r);
        m0_req = r.m0r; m0_we = r.m0w; m0_addr = r.m0a; m0_sel = 4'hF; m0_wdata = r.m0a ^ WD0;
        m1_req = r.m1r; m1_we = r.m1w; m1_addr = r.m1a; m1_sel = 4'h3; m1_wdata = r.m1a ^ WD1;
        m1_lock = r.lk; ram_rdata = r.rd;
    endtask

    task automatic check_out(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    out_t zero_o;

    initial begin
        zero_o = '0;

        // The first cycle after reset is released is IDLE.
        rows.push_back(mk(1,0,'h10, 0,0,0, 0,'hDEADBEEF, 0,0,0,0,0,0,0,0,0));
        rows.push_back(mk(1,0,'h10, 0,0,0, 0,'hDEADBEEF, 1,0,0,1,0,'h10,'hDEADBEEF,0,0));
        rows.push_back(idle_row());
        // Both masters raise a write on the same edge. Master 0 wins, then master 1.
        rows.push_back(mk(1,1,'h20, 1,1,'h30, 0,'h11111111, 0,0,0,0,0,0,0,0,0));
        rows.push_back(mk(1,1,'h20, 1,1,'h30, 0,'h11111111, 1,0,0,1,1,'h20,0,0,0));
        rows.push_back(mk(0,0,0,    1,1,'h30, 0,'h11111111, 0,1,0,1,1,'h30,0,0,0));
        rows.push_back(idle_row());
        // Master 0 issues a stream of writes alone, one access every 2 cycles.
        rows.push_back(mk(1,1,'h0, 0,0,0, 0,0, 0,0,0,0,0,0,0,0,0));
        rows.push_back(mk(1,1,'h0, 0,0,0, 0,0, 1,0,0,1,1,'h0,0,0,0));
        rows.push_back(mk(1,1,'h4, 0,0,0, 0,0, 0,0,0,0,0,0,0,0,0));
        rows.push_back(mk(1,1,'h4, 0,0,0, 0,0, 1,0,0,1,1,'h4,0,0,0));
        rows.push_back(mk(1,1,'h8, 0,0,0, 0,0, 0,0,0,0,0,0,0,0,0));
        rows.push_back(mk(1,1,'h8, 0,0,0, 0,0, 1,0,0,1,1,'h8,0,0,0));
        // Both masters request continuously, so the grants alternate every cycle.
        rows.push_back(mk(1,1,'h40, 1,1,'h50, 0,0, 0,0,0,0,0,0,0,0,0));
        rows.push_back(mk(1,1,'h40, 1,1,'h50, 0,0, 1,0,0,1,1,'h40,0,0,0));
        rows.push_back(mk(1,1,'h44, 1,1,'h50, 0,0, 0,1,0,1,1,'h50,0,0,0));
        rows.push_back(mk(1,1,'h44, 1,1,'h54, 0,0, 1,0,0,1,1,'h44,0,0,0));
        rows.push_back(mk(1,1,'h48, 1,1,'h54, 0,0, 0,1,0,1,1,'h54,0,0,0));
        rows.push_back(mk(1,1,'h48, 0,0,0,    0,0, 1,0,0,1,1,'h48,0,0,0));
        rows.push_back(idle_row());
        // Range boundary: address 0x1000 is out of range, 0xFFC is the last valid word.
        rows.push_back(mk(0,0,0, 1,0,'h1000, 0,'h12345678, 0,0,0,0,0,0,0,0,0));
        rows.push_back(mk(0,0,0, 1,0,'h1000, 0,'h12345678, 0,1,1,0,0,0,0,0,0));
        rows.push_back(mk(0,0,0, 1,0,'hFFC,  0,'hCAFEF00D, 0,0,0,0,0,0,0,0,0));
        rows.push_back(mk(0,0,0, 1,0,'hFFC,  0,'hCAFEF00D, 0,1,0,1,0,'hFFC,0,'hCAFEF00D,0));
        rows.push_back(idle_row());
        // Master 1 write with lock. Master 0 is held off until the lock drops.
        rows.push_back(mk(0,0,0,    1,1,'h60, 1,0, 0,0,0,0,0,0,0,0,0));
        rows.push_back(mk(1,0,'h70, 1,1,'h60, 1,0, 0,1,0,1,1,'h60,0,0,0));
        for (int k = 0; k < 4; k++)
            rows.push_back(mk(1,0,'h70, 0,0,0, 1,0, 0,0,0,0,0,0,0,0,1));
        rows.push_back(mk(1,0,'h70, 0,0,0, 0,0,           0,0,0,0,0,0,0,0,1));
        rows.push_back(mk(1,0,'h70, 0,0,0, 0,'h0BADF00D, 0,0,0,0,0,0,0,0,0));
        rows.push_back(mk(1,0,'h70, 0,0,0, 0,'h0BADF00D, 1,0,0,1,0,'h70,'h0BADF00D,0,0));
        rows.push_back(idle_row());
        // While locked, master 1 is still granted from IDLE over master 0. When
        // master 1 drops the lock inside GNT1, master 0 gets the next cycle.
        rows.push_back(mk(0,0,0,    1,1,'h90, 1,0, 0,0,0,0,0,0,0,0,0));
        rows.push_back(mk(1,0,'h70, 1,1,'h90, 1,0, 0,1,0,1,1,'h90,0,0,0));
        rows.push_back(mk(1,0,'h70, 1,1,'h94, 1,0, 0,0,0,0,0,0,0,0,1));
        rows.push_back(mk(1,0,'h70, 1,1,'h94, 0,0, 0,1,0,1,1,'h94,0,0,1));
        rows.push_back(mk(1,0,'h70, 0,0,0,    0,'h0BADF00D, 1,0,0,1,0,'h70,'h0BADF00D,0,0));
        rows.push_back(idle_row());

        // Reset, with both requests high so that reset has to hold them off.
        drive(mk(1,0,'h10, 1,0,'h20, 1,0, 0,0,0,0,0,0,0,0,0));
        rst = 1'b1;
        #2;
        check_out("reset_async", sample(), zero_o);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_out("first_cycle_after_reset", sample(), zero_o);
        drive(idle_row());

        foreach (rows[i]) begin
            @(posedge clk);
            #1 drive(rows[i]);
            exp_q.push_back(rows[i].exp);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), sample(), exp_q.pop_front());
        end

        // Reset arrives in the middle of a locked GNT1 write.
        @(posedge clk); #1 drive(mk(0,0,0, 1,1,'h80, 1,0, 0,0,0,0,0,0,0,0,0));
        @(posedge clk); #1 drive(mk(0,0,0, 0,0,0,    1,0, 0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        check_bit("lock_taken_ack", m1_ack, 1'b1);
        @(posedge clk); #1 drive(mk(0,0,0, 1,1,'h84, 1,0, 0,0,0,0,0,0,0,0,0));
        @(posedge clk);
        @(negedge clk);
        check_bit("pre_rst_ram_we", ram_we, 1'b1);
        check_bit("pre_rst_locked", locked, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_bit("rst_ram_en", ram_en, 1'b0);
        check_bit("rst_ram_we", ram_we, 1'b0);
        check_bit("rst_m1_ack", m1_ack, 1'b0);
        check_bit("rst_locked", locked, 1'b0);
        @(posedge clk);
        #1 begin rst = 1'b0; drive(idle_row()); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_out($sformatf("post_rst_idle%0d", k), sample(), zero_o);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
